// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state encodings and idle-timeout sizing for the game control unit
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_MACRO   = 4'd2,
    REG_MACRO      = 4'd3,
    ESPERA_MICRO   = 4'd4,
    REG_MICRO      = 4'd5,
    LE_ESTADO      = 4'd6,
    VERIFICA       = 4'd7,
    TROCA          = 4'd8,
    ATUALIZA_MACRO = 4'd9,
    FIM            = 4'd10
  } estado_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 50_000_000;

  // Keeps a one-cycle timeout from collapsing the counter to zero bits.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int TIMEOUT_WIDTH_DEFAULT = cnt_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - idle-cycle counter pulsing fim on its terminal count
module contador_timeout #(
  parameter int CYCLES = 8,
  parameter int WIDTH  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + WIDTH'(1);
    end
  end

  assign fim = enable && !clear && (count == LAST);

endmodule

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore FSM sequencing the ultimate tic-tac-toe datapath
// Optional idle-player forfeit built only when JOGADA_TIMEOUT_EN is defined.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       escolhe_macro,
  input  logic       fim_jogo,
  output logic       zeraEdge,
  output logic       zeraR_micro,
  output logic       zeraR_macro,
  output logic       zeraFlipFlopT,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       sinal_macro,
  output logic       troca_jogador,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado, proximo;
  logic    expira;

`ifdef JOGADA_TIMEOUT_EN
  logic em_espera;
  logic timeout_q;

  assign em_espera = (estado == ESPERA_MACRO) || (estado == ESPERA_MICRO);

  contador_timeout #(
    .CYCLES (TIMEOUT_CYCLES),
    .WIDTH  (cnt_width(TIMEOUT_CYCLES))
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .clear  (!em_espera || tem_jogada),
    .enable (em_espera),
    .fim    (expira)
  );

  // Flag is sticky through FIM so the top level can report why the game ended.
  always_ff @(posedge clock) begin
    if (reset || proximo == PREPARA) begin
      timeout_q <= 1'b0;
    end else if (proximo == FIM && expira) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign expira     = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:        proximo = ESPERA_MACRO;
      ESPERA_MACRO: begin
        if (tem_jogada)  proximo = REG_MACRO;
        else if (expira) proximo = FIM;
        else             proximo = ESPERA_MACRO;
      end
      REG_MACRO:      proximo = ESPERA_MICRO;
      ESPERA_MICRO: begin
        if (tem_jogada)  proximo = REG_MICRO;
        else if (expira) proximo = FIM;
        else             proximo = ESPERA_MICRO;
      end
      REG_MICRO:      proximo = LE_ESTADO;
      LE_ESTADO:      proximo = VERIFICA;
      VERIFICA:       proximo = fim_jogo ? FIM : TROCA;
      TROCA:          proximo = escolhe_macro ? ESPERA_MACRO : ATUALIZA_MACRO;
      ATUALIZA_MACRO: proximo = ESPERA_MICRO;
      FIM:            proximo = iniciar ? PREPARA : FIM;
      default:        proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraEdge        = 1'b0;
    zeraR_micro     = 1'b0;
    zeraR_macro     = 1'b0;
    zeraFlipFlopT   = 1'b0;
    registraR_macro = 1'b0;
    registraR_micro = 1'b0;
    sinal_macro     = 1'b0;
    troca_jogador   = 1'b0;
    pronto          = 1'b0;
    case (estado)
      PREPARA: begin
        zeraEdge      = 1'b1;
        zeraR_micro   = 1'b1;
        zeraR_macro   = 1'b1;
        zeraFlipFlopT = 1'b1;
      end
      ESPERA_MACRO: sinal_macro = 1'b1;
      REG_MACRO: begin
        sinal_macro     = 1'b1;
        registraR_macro = 1'b1;
      end
      REG_MICRO:      registraR_micro = 1'b1;
      TROCA:          troca_jogador   = 1'b1;
      // Macro cell is redirected to the micro cell just played.
      ATUALIZA_MACRO: registraR_macro = 1'b1;
      FIM:            pronto          = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
